ex_muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the EX stage and replaces the vendor divider IP cores. It accepts one operation through a valid/ready handshake and computes it in its own state machine. Division uses an iterative restoring divider; multiplication uses a configurable retiming pipeline. The result is held until the downstream stage accepts it. A flush input cancels the operation in flight on exceptions or branch redirects.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_div_step.sv | 21 ++
 rtl/ex_muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and decode helper for the EX-stage multiply/divide unit.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL   = 3'b000;
   localparam logic [2:0] OP_MULH  = 3'b001;
   localparam logic [2:0] OP_MULHU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b100;
   localparam logic [2:0] OP_MOD   = 3'b101;
   localparam logic [2:0] OP_DIVU  = 3'b110;
   localparam logic [2:0] OP_MODU  = 3'b111;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV_SETUP,
      DIV_ITER,
      DIV_FIX,
      DONE
   } state_t;

   // Op code 011 has bit 2 clear, so it falls into the multiply class.
   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module muldiv_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   assign shifted = {rem, dividend_bit};
   assign diff    = shifted - {1'b0, divisor};
   // The partial remainder is below the divisor, so the top diff bit is a clean borrow.
   assign q_bit    = ~diff[WIDTH];
   assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide unit for the EX stage; pipelined multiplier, restoring divider.
// Optional MULDIV_DZ_FAST_EN: divide by zero completes straight from IDLE and raises out_dz.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_src1,
   input  logic [WIDTH-1:0] in_src2,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result
`ifdef MULDIV_DZ_FAST_EN
   ,
   output logic             out_dz
`endif
);

   localparam int DC_W = $clog2(WIDTH);
   localparam int MC_W = $clog2(MUL_STAGES + 1);

   state_t                 state, state_next;
   logic [DC_W-1:0]        div_cnt;
   logic [MC_W-1:0]        mul_cnt;
   logic [2:0]             op_q;
   logic [WIDTH-1:0]       src1_q, src2_q;
   logic [WIDTH-1:0]       div_q, div_r, div_d;
   logic                   q_neg, r_neg;
   logic [WIDTH-1:0]       step_rem;
   logic                   step_qbit;
   logic                   accept, dz_fast;
   logic                   mul_ext, mul_hi, div_signed, div_rem_op, a_neg, b_neg;
   logic [2*WIDTH-1:0]     mul_a, mul_b, mul_p;
   logic [2*WIDTH-1:0]     mul_pipe [MUL_STAGES];
   logic [WIDTH-1:0]       mul_res, fix_res;

   // Valid/ready: a transfer happens on an edge where valid and ready are both high;
   // in_ready and out_valid are functions of state and flush only, never of the partner's signal.
   assign in_ready  = (state == IDLE) & ~flush;
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;

`ifdef MULDIV_DZ_FAST_EN
   assign dz_fast = is_div(in_op) && (in_src2 == '0);
`else
   assign dz_fast = 1'b0;
`endif

   // Low 2W bits of the (W+1)x(W+1) signed product; only MULH sign-extends its operands.
   assign mul_ext = (in_op == OP_MULH);
   assign mul_a   = {{WIDTH{mul_ext & in_src1[WIDTH-1]}}, in_src1};
   assign mul_b   = {{WIDTH{mul_ext & in_src2[WIDTH-1]}}, in_src2};
   assign mul_p   = mul_a * mul_b;

   assign mul_hi  = (op_q == OP_MULH) || (op_q == OP_MULHU);
   assign mul_res = mul_hi ? mul_pipe[MUL_STAGES-1][2*WIDTH-1:WIDTH]
                           : mul_pipe[MUL_STAGES-1][WIDTH-1:0];

   assign div_signed = (op_q == OP_DIV) || (op_q == OP_MOD);
   assign div_rem_op = (op_q == OP_MOD) || (op_q == OP_MODU);
   assign a_neg      = div_signed & src1_q[WIDTH-1];
   assign b_neg      = div_signed & src2_q[WIDTH-1];

   muldiv_div_step #(.WIDTH(WIDTH)) u_step (
      .rem          (div_r),
      .dividend_bit (div_q[WIDTH-1]),
      .divisor      (div_d),
      .rem_next     (step_rem),
      .q_bit        (step_qbit)
   );

   always_comb begin
      fix_res = div_q;
      if (src2_q == '0)
         fix_res = div_rem_op ? src1_q : '1;
      else if (div_rem_op)
         fix_res = r_neg ? -div_r : div_r;
      else
         fix_res = q_neg ? -div_q : div_q;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (dz_fast)              state_next = DONE;
               else if (is_div(in_op))   state_next = DIV_SETUP;
               else                      state_next = MUL;
            end
         end
         MUL:       if (mul_cnt == MC_W'(MUL_STAGES - 1)) state_next = DONE;
         DIV_SETUP: state_next = DIV_ITER;
         DIV_ITER:  if (div_cnt == DC_W'(WIDTH - 1)) state_next = DIV_FIX;
         DIV_FIX:   state_next = DONE;
         DONE:      if (out_ready) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         mul_cnt <= '0;
         div_cnt <= '0;
      end else begin
         state   <= state_next;
         mul_cnt <= (state == MUL && state_next == MUL) ? mul_cnt + MC_W'(1) : '0;
         div_cnt <= (state == DIV_ITER && state_next == DIV_ITER) ? div_cnt + DC_W'(1) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q       <= '0;
         src1_q     <= '0;
         src2_q     <= '0;
         div_q      <= '0;
         div_r      <= '0;
         div_d      <= '0;
         q_neg      <= 1'b0;
         r_neg      <= 1'b0;
         out_result <= '0;
`ifdef MULDIV_DZ_FAST_EN
         out_dz     <= 1'b0;
`endif
         for (int i = 0; i < MUL_STAGES; i++) mul_pipe[i] <= '0;
      end else begin
         if (accept) begin
            op_q        <= in_op;
            src1_q      <= in_src1;
            src2_q      <= in_src2;
            mul_pipe[0] <= mul_p;
         end
         for (int i = 1; i < MUL_STAGES; i++) mul_pipe[i] <= mul_pipe[i-1];
         // A flush must leave out_result untouched, so every DONE entry is gated by it.
         if (!flush) begin
            case (state)
               IDLE: begin
`ifdef MULDIV_DZ_FAST_EN
                  if (accept && dz_fast) begin
                     out_result <= (in_op == OP_MOD || in_op == OP_MODU) ? in_src1 : '1;
                     out_dz     <= 1'b1;
                  end
`endif
               end
               MUL: begin
                  if (state_next == DONE) begin
                     out_result <= mul_res;
`ifdef MULDIV_DZ_FAST_EN
                     out_dz     <= 1'b0;
`endif
                  end
               end
               DIV_SETUP: begin
                  div_q <= a_neg ? -src1_q : src1_q;
                  div_d <= b_neg ? -src2_q : src2_q;
                  div_r <= '0;
                  q_neg <= a_neg ^ b_neg;
                  r_neg <= a_neg;
               end
               DIV_ITER: begin
                  div_r <= step_rem;
                  div_q <= {div_q[WIDTH-2:0], step_qbit};
               end
               DIV_FIX: begin
                  out_result <= fix_res;
`ifdef MULDIV_DZ_FAST_EN
                  out_dz     <= 1'b0;
`endif
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (WIDTH=32, MUL_STAGES=2), with or without MULDIV_DZ_FAST_EN.
module tb_ex_muldiv_unit;

   localparam int W       = 32;
   localparam int MS      = 2;
   localparam int MUL_LAT = MS + 1;
   localparam int DIV_LAT = W + 3;
`ifdef MULDIV_DZ_FAST_EN
   localparam int DZ_LAT  = 1;
`else
   localparam int DZ_LAT  = W + 3;
`endif

   logic         clk = 1'b0;
   logic         reset, in_valid, in_ready, flush, out_valid, out_ready;
   logic [2:0]   in_op;
   logic [W-1:0] in_src1, in_src2, out_result;
   logic         out_dz;

   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      int           lat;
   } vec_t;
   vec_t vt[$];

   always #5 clk = ~clk;

   ex_muldiv_unit #(.WIDTH(W), .MUL_STAGES(MS)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_src1    (in_src1),
      .in_src2    (in_src2),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result)
`ifdef MULDIV_DZ_FAST_EN
      ,
      .out_dz     (out_dz)
`endif
   );
`ifndef MULDIV_DZ_FAST_EN
   assign out_dz = 1'b0;
`endif

   function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      longint sa, sb;
      longint unsigned ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = 64'(a);
      ub = 64'(b);
      case (op)
         3'b001: begin p = 64'(sa * sb); return p[63:32]; end
         3'b010: begin p = ua * ub;      return p[63:32]; end
         3'b100: return (b == 0) ? '1 : W'(sa / sb);
         3'b101: return (b == 0) ? a  : W'(sa % sb);
         3'b110: return (b == 0) ? '1 : W'(ua / ub);
         3'b111: return (b == 0) ? a  : W'(ua % ub);
         default: begin p = ua * ub; return p[31:0]; end
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] op, input logic [W-1:0] b);
      if (!op[2]) return MUL_LAT;
      return (b == 0) ? DZ_LAT : DIV_LAT;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 32'd1;
         2: return '1;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return W'($urandom);
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int t = 0;
      @(negedge clk);
      in_op = op; in_src1 = a; in_src2 = b; in_valid = 1'b1;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", t);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 200);
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic run_vec(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
      int lat;
      issue(op, a, b);
      wait_valid(lat);
      check({name, "_res"}, out_result, exp);
      check({name, "_lat"}, lat, exp_lat);
`ifdef MULDIV_DZ_FAST_EN
      check({name, "_dz"}, out_dz, (op[2] && b == 0));
`endif
      take();
   endtask

   initial begin
      int lat;
      logic seen;
      logic [2:0] op;
      logic [W-1:0] a, b;

      reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_op = '0; in_src1 = '0; in_src2 = '0;

      vt.push_back('{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT});
      vt.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT});
      vt.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT});
      vt.push_back('{3'b011, 32'd5,         32'd6,         32'd30,        MUL_LAT});
      vt.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT});
      vt.push_back('{3'b101, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT});
      vt.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, DIV_LAT});
      vt.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT});
      vt.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         DIV_LAT});
      vt.push_back('{3'b111, 32'hFFFF_FFFF, 32'h10,        32'hF,         DIV_LAT});
      vt.push_back('{3'b110, 32'h1234,      32'h0,         32'hFFFF_FFFF, DZ_LAT});
      vt.push_back('{3'b111, 32'h1234,      32'h0,         32'h1234,      DZ_LAT});
      vt.push_back('{3'b100, 32'd7,         32'h0,         32'hFFFF_FFFF, DZ_LAT});
      vt.push_back('{3'b101, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, DZ_LAT});

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_result", out_result, 0);
      check("rst_out_dz", out_dz, 0);

      foreach (vt[i])
         run_vec($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat);

      // Flush in the middle of a divide.
      issue(3'b100, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      check("flush_in_ready_low", in_ready, 0);
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_in_ready", in_ready, 1);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("flush_no_valid", seen, 0);
      run_vec("after_flush_mul", 3'b000, 32'd3, 32'd4, 32'd12, MUL_LAT);

      // Flush in DONE while out_ready is high discards the result.
      issue(3'b000, 32'd5, 32'd5);
      wait_valid(lat);
      check("done_flush_valid_before", out_valid, 1);
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      check("done_flush_valid", out_valid, 0);
      check("done_flush_ready", in_ready, 1);

      // Offer together with flush must not be accepted.
      @(negedge clk);
      in_op = 3'b000; in_src1 = 32'd9; in_src2 = 32'd9; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; flush = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("flush_offer_ignored", seen, 0);

      // Result held while downstream stalls.
      issue(3'b110, 32'd1000, 32'd7);
      wait_valid(lat);
      check("hold_first", out_result, 142);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("hold_res%0d", i), out_result, 142);
         check($sformatf("hold_valid%0d", i), out_valid, 1);
         check($sformatf("hold_ready%0d", i), in_ready, 0);
      end
      take();
      @(negedge clk);
      check("hold_release_valid", out_valid, 0);
      check("hold_release_ready", in_ready, 1);

      // Reset in the middle of a divide.
      issue(3'b100, 32'd50, 32'd3);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("midrst_valid", out_valid, 0);
      check("midrst_ready", in_ready, 1);
      check("midrst_result", out_result, 0);
      run_vec("after_rst_div", 3'b100, 32'd50, 32'd3, 32'd16, DIV_LAT);

      // Randomized operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         exp_q.push_back(model(op, a, b));
         issue(op, a, b);
         wait_valid(lat);
         check($sformatf("rnd%0d_lat", i), lat, model_lat(op, b));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         check($sformatf("rnd%0d_res op%0d a%0h b%0h", i, op, a, b), out_result, exp_q.pop_front());
         take();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
